// File: rtl/uart_rx_frame_check.sv
// UART receive frame checker and deserialiser.
// Consumes one majority-voted bit per bit_valid strobe, tracks frame position,
// checks start/parity/stop bits and publishes only error-free words on p_data.
// Optional build macro: UART_BREAK_DETECT_EN adds brk_det, which reports an
// all-zero frame with a low stop bit as a line break instead of a stop error.
module uart_rx_frame_check #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  frame_start,
  input  logic                  bit_valid,
  input  logic                  sampled_bit,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  strt_glitch,
  output logic                  par_err,
  output logic                  stp_err,
`ifdef UART_BREAK_DETECT_EN
  output logic                  brk_det,
`endif
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  busy
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_par_en_l;
  logic                  r_par_typ_l;
  logic                  r_frame_err;
`ifdef UART_BREAK_DETECT_EN
  logic                  r_par_bit;
  logic                  r_brk_det;
  logic                  w_brk_det;
`endif

  logic                  r_strt_glitch;
  logic                  r_par_err;
  logic                  r_stp_err;
  logic [DATA_WIDTH-1:0] r_p_data;
  logic                  r_data_valid;
  logic                  r_busy;

  logic                  w_last_data;
  logic                  w_last_stop;
  logic                  w_strt_glitch;
  logic                  w_par_err;
  logic                  w_stop_low;
  logic                  w_stp_err;
  logic                  w_load;

  assign w_last_data = (r_cnt == CNT_W'(DATA_WIDTH - 1));
  assign w_last_stop = (r_cnt == CNT_W'(STOP_BITS - 1));

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic; frame_start is only honoured from IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (frame_start) w_state_nxt = S_START;
      S_START:  if (bit_valid) w_state_nxt = sampled_bit ? S_IDLE : S_DATA;
      S_DATA:   if (bit_valid && w_last_data) w_state_nxt = r_par_en_l ? S_PARITY : S_STOP;
      S_PARITY: if (bit_valid) w_state_nxt = S_STOP;
      S_STOP:   if (bit_valid && (!sampled_bit || w_last_stop)) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode: next values of the registered pulses and the p_data load
  always_comb begin
    w_strt_glitch = (r_state == S_START) && bit_valid && sampled_bit;
    w_par_err     = (r_state == S_PARITY) && bit_valid &&
                    (sampled_bit != ((^r_shift) ^ r_par_typ_l));
    w_stop_low    = (r_state == S_STOP) && bit_valid && !sampled_bit;
    w_load        = (r_state == S_STOP) && bit_valid && sampled_bit &&
                    w_last_stop && !r_frame_err;
`ifdef UART_BREAK_DETECT_EN
    w_brk_det     = w_stop_low && (r_shift == '0) && !r_par_bit;
    w_stp_err     = w_stop_low && !w_brk_det;
`else
    w_stp_err     = w_stop_low;
`endif
  end

  // Frame datapath: config capture, bit counter, shift register, error flag
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_shift     <= '0;
      r_cnt       <= '0;
      r_par_en_l  <= 1'b0;
      r_par_typ_l <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_BREAK_DETECT_EN
      r_par_bit   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (frame_start) begin
          r_par_en_l  <= par_en;
          r_par_typ_l <= par_typ;
          r_cnt       <= '0;
          r_frame_err <= 1'b0;
`ifdef UART_BREAK_DETECT_EN
          r_par_bit   <= 1'b0;
`endif
        end
        S_DATA: if (bit_valid) begin
          r_shift <= {sampled_bit, r_shift[DATA_WIDTH-1:1]};
          r_cnt   <= w_last_data ? '0 : r_cnt + CNT_W'(1);
        end
        S_PARITY: if (bit_valid) begin
          if (w_par_err) r_frame_err <= 1'b1;
`ifdef UART_BREAK_DETECT_EN
          r_par_bit <= sampled_bit;
`endif
        end
        S_STOP: if (bit_valid && sampled_bit) r_cnt <= r_cnt + CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_strt_glitch <= 1'b0;
      r_par_err     <= 1'b0;
      r_stp_err     <= 1'b0;
      r_p_data      <= '0;
      r_data_valid  <= 1'b0;
      r_busy        <= 1'b0;
`ifdef UART_BREAK_DETECT_EN
      r_brk_det     <= 1'b0;
`endif
    end else begin
      r_strt_glitch <= w_strt_glitch;
      r_par_err     <= w_par_err;
      r_stp_err     <= w_stp_err;
      r_data_valid  <= w_load;
      r_busy        <= (w_state_nxt != S_IDLE);
      if (w_load) r_p_data <= r_shift;
`ifdef UART_BREAK_DETECT_EN
      r_brk_det     <= w_brk_det;
`endif
    end
  end

  assign strt_glitch = r_strt_glitch;
  assign par_err     = r_par_err;
  assign stp_err     = r_stp_err;
  assign p_data      = r_p_data;
  assign data_valid  = r_data_valid;
  assign busy        = r_busy;
`ifdef UART_BREAK_DETECT_EN
  assign brk_det     = r_brk_det;
`endif

endmodule
